// File: rtl/banked_mem_responder.sv
// Banked memory responder. It stores MEM_LINES 256-bit lines and accepts
// 4-beat line writes and queued line reads. Each read line is returned as
// four 64-bit beats after a fixed latency, tagged with the line address.
module banked_mem_responder #(
  parameter int MEM_LINES    = 16,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        read,
  input  logic        write,
  input  logic [63:0] wdata,
  output logic        ready,
  output logic [31:0] raddr,
  output logic [63:0] rdata,
  output logic        rvalid,
  output logic        error
);

  localparam int LW   = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int QW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNTW = QW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(QUEUE_DEPTH);
  localparam logic [CW-1:0]   LOAD_C  = CW'(READ_LATENCY - 1);

  // The write state encoding equals the index of the word the beat writes.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BEAT1 = 2'd1,
    W_BEAT2 = 2'd2,
    W_BEAT3 = 2'd3
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BEAT = 1'b1
  } rstate_e;

  // Line storage and write burst state.
  logic [63:0] mem_q [MEM_LINES][4];
  wstate_e     wstate_q, wstate_d;
  logic [31:0] waddr_q, waddr_d;
  logic        error_q, error_d;
  logic        mem_we;
  logic [LW-1:0] mem_line;
  logic [1:0]  mem_word;
  logic        push;

  // Read queue and response state.
  logic [31:0]     q_addr_q [QUEUE_DEPTH];
  logic [CW-1:0]   q_cnt_q  [QUEUE_DEPTH];
  logic [QW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  rstate_e         rstate_q, rstate_d;
  logic [1:0]      beat_q, beat_d;
  logic            pop;
  logic [31:0]     head_addr;
  logic [CW-1:0]   head_cnt;

  // Registered outputs.
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [63:0] rdata_q, rdata_d;

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign raddr  = raddr_q;
  assign rdata  = rdata_q;
  assign error  = error_q;

  // Request decode, protocol checks and write burst sequencing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    error_d  = error_q;
    mem_we   = 1'b0;
    mem_line = waddr_q[5 +: LW];
    mem_word = 2'd0;
    push     = 1'b0;
    if (wstate_q == W_IDLE) begin
      if (ready_q && (read || write)) begin
        if ((read && write) || (addr[4:0] != 5'd0)) begin
          error_d = 1'b1;
        end else if (write) begin
          mem_we   = 1'b1;
          mem_line = addr[5 +: LW];
          waddr_d  = addr;
          wstate_d = W_BEAT1;
        end else begin
          push = 1'b1;
        end
      end
    end else begin
      // Reads are not accepted mid-burst; the beat itself still proceeds.
      if (read) error_d = 1'b1;
      if (write) begin
        mem_we   = 1'b1;
        mem_word = wstate_q;
        if (addr != waddr_q) error_d = 1'b1;
        wstate_d = (wstate_q == W_BEAT3) ? W_IDLE : wstate_e'(wstate_q + 2'd1);
      end else begin
        error_d  = 1'b1;
        wstate_d = W_IDLE;
      end
    end
  end

  // Response sequencing: start a line when the head is due, stream four beats, pop.
  always_comb begin
    rstate_d  = rstate_q;
    beat_d    = beat_q;
    pop       = 1'b0;
    rvalid_d  = 1'b0;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    head_addr = q_addr_q[rd_ptr_q];
    head_cnt  = q_cnt_q[rd_ptr_q];
    unique case (rstate_q)
      R_IDLE: begin
        if ((count_q != '0) && (head_cnt == '0)) begin
          rvalid_d = 1'b1;
          raddr_d  = head_addr;
          rdata_d  = mem_q[head_addr[5 +: LW]][0];
          beat_d   = 2'd1;
          rstate_d = R_BEAT;
        end
      end
      R_BEAT: begin
        rvalid_d = 1'b1;
        raddr_d  = head_addr;
        rdata_d  = mem_q[head_addr[5 +: LW]][beat_q];
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          pop      = 1'b1;
          rstate_d = R_IDLE;
        end
      end
    endcase
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    // Computed with this edge's pop applied, so a full queue that pops admits one entry next.
    ready_d = (count_d < DEPTH_C) || (wstate_d != W_IDLE);
  end

  // Line storage; written by the write path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is flops, not an SRAM macro, so it can and must clear to zero on reset.
      for (int l = 0; l < MEM_LINES; l++) begin
        for (int w = 0; w < 4; w++) mem_q[l][w] <= '0;
      end
    end else if (mem_we) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q[mem_line][mem_word] <= wdata;
    end
  end

  // Write burst state and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      error_q  <= error_d;
    end
  end

  // Read queue: per-entry countdown saturates at zero; a push loads a fresh countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_cnt_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_cnt_q[i] != '0) q_cnt_q[i] <= q_cnt_q[i] - 1'b1;
      end
      if (push) begin
        q_addr_q[wr_ptr_q] <= addr;
        q_cnt_q[wr_ptr_q]  <= LOAD_C;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Response state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      beat_q   <= 2'd0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: directed scenarios plus randomized write
// bursts and read batches, checked by a scoreboard against a line-level model.
module tb_banked_mem_responder;

  localparam int L     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic        ready;
  logic [31:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        error;

  banked_mem_responder #(
    .MEM_LINES(16), .READ_LATENCY(L), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .read(read), .write(write),
    .wdata(wdata), .ready(ready), .raddr(raddr), .rdata(rdata),
    .rvalid(rvalid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    int          e;
  } beat_t;

  beat_t       exp_q[$];
  int          last_q[$];
  logic [63:0] mdl [16][4];
  int          edge_n = 0;
  int          last_beat = 0;
  bit          err_exp = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every response beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got raddr %0h rdata %0h, expected no beat", raddr, rdata);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("raddr", raddr, b.a);
        check("rdata", rdata, b.d);
        check("beat_edge", edge_n, b.e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (mdl[l, w]) mdl[l][w] = '0;
    exp_q.delete();
    last_q.delete();
    last_beat = 0;
    err_exp = 1'b0;
  endtask

  // Queue occupancy after the latest edge = reads whose last beat is still ahead.
  task automatic check_ready();
    int n = 0;
    foreach (last_q[i]) if (last_q[i] > edge_n) n++;
    check("ready", ready, (n < DEPTH));
  endtask

  task automatic wait_ready(input string who);
    int g = 0;
    while (!ready && g < 50) begin
      tick();
      check_ready();
      g++;
    end
    if (!ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got ready 0, expected 1 within 50 cycles", who);
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    int acc, first;
    wait_ready("read");
    addr = a;
    read = 1'b1;
    tick();
    read = 1'b0;
    acc   = edge_n;
    first = (acc + L > last_beat + 1) ? acc + L : last_beat + 1;
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.a = a;
      b.d = mdl[a[8:5]][k];
      b.e = first + k;
      exp_q.push_back(b);
    end
    last_beat = first + 3;
    last_q.push_back(first + 3);
    check_ready();
  endtask

  // Writes nb beats of a burst; nb < 4 drops write for one cycle afterwards.
  task automatic do_write(input logic [31:0] a, input logic [63:0] w0, input logic [63:0] w1,
                          input logic [63:0] w2, input logic [63:0] w3, input int nb);
    logic [63:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    wait_ready("write");
    for (int k = 0; k < nb; k++) begin
      addr  = a;
      write = 1'b1;
      wdata = w[k];
      tick();
      mdl[a[8:5]][k] = w[k];
      if (k < 3) check("burst_ready", ready, 1'b1);
    end
    write = 1'b0;
    if (nb < 4) begin
      tick();
      err_exp = 1'b1;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      tick();
      g++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    last_q.delete();
  endtask

  function automatic logic [31:0] rand_line_addr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:9], r[3:0], 5'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    read  = 1'b0;
    write = 1'b0;
    wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_raddr", raddr, 32'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_error", error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", ready, 1'b0);
    tick();
    check("ready_after_release", ready, 1'b1);

    // Write a line, then read it back after the fixed latency.
    do_write(32'h20, 64'h11, 64'h22, 64'h33, 64'h44, 4);
    do_read(32'h20);
    drain();
    check("error_clean", error, 1'b0);

    // Four back-to-back reads fill the queue; sixteen beats stream without a bubble.
    do_read(32'h00);
    do_read(32'h20);
    do_read(32'h40);
    do_read(32'h60);
    check("ready_full", ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_ready();
    end
    drain();
    check("error_clean2", error, 1'b0);

    // Misaligned read is dropped and flags error; later reads still work.
    wait_ready("misaligned");
    addr = 32'h24;
    read = 1'b1;
    tick();
    read = 1'b0;
    err_exp = 1'b1;
    check("error_misaligned", error, err_exp);
    repeat (10) tick();
    do_read(32'h20);
    drain();
    check("error_sticky", error, err_exp);

    // Burst aborted after two beats keeps those words, leaves the rest zero.
    do_write(32'h40, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 2);
    check("error_abort", error, err_exp);
    do_read(32'h40);
    drain();

    // Read and write together: flagged and dropped entirely.
    wait_ready("rw");
    addr  = 32'h60;
    read  = 1'b1;
    write = 1'b1;
    wdata = 64'hDEAD_BEEF;
    tick();
    read  = 1'b0;
    write = 1'b0;
    check("error_rw", error, err_exp);
    check("rw_no_burst_ready", ready, 1'b1);
    repeat (6) tick();
    do_read(32'h60);
    drain();

    // Randomized write bursts followed by read batches with random spacing.
    for (int round = 0; round < 12; round++) begin
      int nw, nr;
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) begin
        logic [63:0] r0, r1, r2, r3;
        r0 = {$urandom(), $urandom()};
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        r3 = {$urandom(), $urandom()};
        do_write(rand_line_addr(), r0, r1, r2, r3, 4);
      end
      nr = $urandom_range(1, 8);
      for (int i = 0; i < nr; i++) begin
        int gap;
        do_read(rand_line_addr());
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          tick();
          check_ready();
        end
      end
      drain();
      check("error_random", error, err_exp);
    end

    // Reset during beat 2 of a response clears everything at once.
    begin
      int first, g;
      do_read(32'h20);
      first = last_beat - 3;
      g = 0;
      while (edge_n < first + 2 && g < 50) begin
        tick();
        g++;
      end
      check("beat2_visible", rvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("reset_rvalid", rvalid, 1'b0);
      check("reset_ready", ready, 1'b0);
      check("reset_error", error, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rerelease_ready_low", ready, 1'b0);
      tick();
      check("rerelease_ready_high", ready, 1'b1);
      repeat (8) tick();
      check("post_reset_no_beat", rvalid, 1'b0);
      do_read(32'h20);
      drain();
      do_read(32'h1E0);
      drain();
      check("post_reset_error", error, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
